// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low key matrix one row at a time and debounces whole
//   frames. Each new key press becomes an event delivered over a
//   valid/ready handshake.
//
//   Optional feature macro: KEYPAD_REPEAT_EN
//     When defined, a single held key produces auto-repeat events: the first
//     after REPEAT_DELAY frames, then one every REPEAT_RATE frames.
//     When undefined, the REPEAT_* parameters have no effect.
//
//   Ports
//     clk        clock
//     rst        asynchronous, active-high reset
//     row_n      row drive; the single low bit selects the scanned row
//     col_n      column sense (pulled up); low = key pressed on selected row
//     key_valid  event available
//     key_code   event key index, row*4 + col
//     key_ready  consumer accepts the event
//     keys       debounced key map, bit row*4+col, 1 = pressed
//     overrun    sticky flag: an event was lost
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic [15:0] keys,
  output logic        overrun
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic {ST_EMPTY, ST_VALID} state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(m[i]);
    return n;
  endfunction

  function automatic logic [3:0] lowest16(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  logic [3:0]       r_col_s1;
  logic [3:0]       r_col_s2;
  logic [1:0]       r_row;
  logic [SET_W-1:0] r_settle;
  logic [11:0]      r_raw;
  logic [15:0]      r_prev;
  logic [DB_W-1:0]  r_stable;
  logic [15:0]      r_pending;
  state_t           r_state;

  logic            w_sample;
  logic            w_frame_end;
  logic            w_ghost;
  logic            w_update;
  logic            w_rep_fire;
  logic [15:0]     w_frame;
  logic [15:0]     w_rise;
  logic [15:0]     w_set;
  logic [15:0]     w_held;
  logic [15:0]     w_lost;
  logic [15:0]     w_pend_m;
  logic [15:0]     w_sel_src;
  logic [3:0]      w_sel;
  logic [DB_W-1:0] w_stable_nx;

  // ---- scan: sample on the last clock of each row window ----
  assign w_sample    = (r_settle == SET_LAST);
  assign w_frame_end = w_sample && (r_row == 2'd3);
  // Row 3 is never stored; it is taken straight from the synchronizer.
  assign w_frame     = {~r_col_s2, r_raw};

  // ---- debounce: whole-frame comparison ----
  assign w_ghost     = (popcount16(w_frame) > 5'd2);
  assign w_stable_nx = (w_frame != r_prev) ? DB_W'(1) :
                       (r_stable == DB_MAX) ? r_stable : r_stable + 1'b1;
  assign w_update    = w_frame_end && !w_ghost && (w_stable_nx == DB_MAX) &&
                       (w_frame != keys);

  // ---- event sources ----
  assign w_rise   = w_update ? (w_frame & ~keys) : 16'h0;
  assign w_set    = w_rise | (w_rep_fire ? keys : 16'h0);
  // An event parked in the output register counts as still pending: a second
  // press of the same key before it is taken is a lost event, not a new one.
  assign w_held   = (key_valid && !key_ready) ? (16'h1 << key_code) : 16'h0;
  assign w_lost   = w_set & (r_pending | w_held);
  assign w_pend_m = r_pending | (w_set & ~w_held);
  // An empty FSM picks from the registered mask so key_valid follows the
  // keys update by one clock; a handshake picks from the merged mask.
  assign w_sel_src = (r_state == ST_EMPTY) ? r_pending : w_pend_m;
  assign w_sel     = lowest16(w_sel_src);

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] r_rep_cnt;
  logic        w_keys_one;

  assign w_keys_one = (popcount16(keys) == 5'd1);
  assign w_rep_fire = w_frame_end && !w_update && w_keys_one &&
                      (r_rep_cnt == 16'd1);

  // Frames remaining until the next repeat; reloaded by every keys update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
    end else if (w_update) begin
      r_rep_cnt <= 16'(REPEAT_DELAY);
    end else if (w_frame_end && w_keys_one && (r_rep_cnt != 16'd0)) begin
      r_rep_cnt <= (r_rep_cnt == 16'd1) ? 16'(REPEAT_RATE) : r_rep_cnt - 16'd1;
    end
  end
`else
  // Repeat disabled; the REPEAT_* parameters have no effect.
  assign w_rep_fire = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
      row_n    <= 4'hF;
      r_row    <= '0;
      r_settle <= '0;
      r_raw    <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      keys     <= '0;
      overrun  <= 1'b0;
    end else begin
      r_col_s1 <= col_n;
      r_col_s2 <= r_col_s1;
      // Registered drive: row_n moves one clock after the row index advances.
      row_n    <= ~(4'b0001 << r_row);

      if (w_sample) begin
        r_settle <= '0;
        r_row    <= r_row + 2'd1;
        if (r_row != 2'd3) r_raw[{r_row, 2'b00} +: 4] <= ~r_col_s2;
      end else begin
        r_settle <= r_settle + 1'b1;
      end

      if (w_frame_end) begin
        if (w_ghost) begin
          r_stable <= '0;
        end else begin
          r_stable <= w_stable_nx;
          r_prev   <= w_frame;
          if (w_update) keys <= w_frame;
        end
      end

      if (w_lost != 16'h0) overrun <= 1'b1;
    end
  end

  // ---- output FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      key_valid <= 1'b0;
      key_code  <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_m;
      case (r_state)
        ST_EMPTY: begin
          if (r_pending != 16'h0) begin
            key_code  <= w_sel;
            r_pending <= w_pend_m & ~(16'h1 << w_sel);
            key_valid <= 1'b1;
            r_state   <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (key_ready) begin
            if (w_pend_m != 16'h0) begin
              key_code  <= w_sel;
              r_pending <= w_pend_m & ~(16'h1 << w_sel);
            end else begin
              key_valid <= 1'b0;
              r_state   <= ST_EMPTY;
            end
          end
        end
        default: begin
          key_valid <= 1'b0;
          r_state   <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a behavioural 4x4 key matrix drives col_n
// from row_n; delivered events are scored against an expected-code queue.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEBNC  = 3;
  localparam int FRAME  = 4 * SETTLE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic [15:0] keys;
  logic        overrun;

  logic [15:0] pressed = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0]  exp_q[$];
  int          got_t[$];
  bit          sb_on = 1'b1;
  int          keys_changes = 0;
  logic [15:0] keys_last = 16'h0;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEBNC),
    .REPEAT_DELAY  (8),
    .REPEAT_RATE   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .keys     (keys),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~pressed[r*4 +: 4];
  end

  // Scoreboard: an event transfers on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (key_valid && key_ready) begin
      got_t.push_back(cyc);
      if (sb_on) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got code %0d, expected no event", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (key_code !== e) begin
            n_bad++;
            $display("FAIL event_code: got %0d, expected %0d", key_code, e);
          end
        end
      end
    end
    if (keys !== keys_last) keys_changes++;
    keys_last = keys;
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    got_t.delete();
    sb_on = 1'b1;
    rst = 1'b0;
    keys_changes = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    @(negedge clk);
    key_ready = 1'b0;
    pressed = 16'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (row_n !== 4'hF) begin n_bad++; $display("FAIL reset_row_n: got %b, expected 1111", row_n); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b, expected 0", key_valid); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_key_code: got %0d, expected 0", key_code); end
    n_cmp++; if (keys !== 16'h0) begin n_bad++; $display("FAIL reset_keys: got %h, expected 0000", keys); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    exp_q.delete();
    got_t.delete();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (((k - 1) / SETTLE) % 4));
      n_cmp++;
      if (row_n !== exp_row) begin
        n_bad++;
        $display("FAIL scan_row_n[%0d]: got %b, expected %b", k, row_n, exp_row);
      end
    end
  endtask

  task automatic test_clean_press();
    int lat;
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0040;
    exp_q.push_back(4'd6);
    lat = -1;
    for (int i = 1; i <= 10 * FRAME && lat < 0; i++) begin
      @(negedge clk);
      if (keys != 16'h0) lat = i;
    end
    n_cmp++;
    if (lat < 36 || lat > 64) begin
      n_bad++;
      $display("FAIL press_latency: got %0d cycles, expected 36..64", lat);
    end
    n_cmp++; if (keys !== 16'h0040) begin n_bad++; $display("FAIL press_keys: got %h, expected 0040", keys); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_valid_same_cycle: got %b, expected 0", key_valid); end
    @(negedge clk);
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid_next: got %b, expected 1", key_valid); end
    n_cmp++; if (key_code !== 4'd6) begin n_bad++; $display("FAIL press_code: got %0d, expected 6", key_code); end
    wait_frames(6);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL press_events_pending: got %0d undelivered, expected 0", exp_q.size()); end
    n_cmp++; if (keys_changes != 1) begin n_bad++; $display("FAIL press_keys_changes: got %0d, expected 1", keys_changes); end
    pressed = 16'h0;
    wait_frames(5);
    n_cmp++; if (keys !== 16'h0) begin n_bad++; $display("FAIL release_keys: got %h, expected 0000", keys); end
  endtask

  task automatic test_bounce();
    do_reset();
    key_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_frames(1);
    end
    n_cmp++; if (keys !== 16'h0) begin n_bad++; $display("FAIL bounce_keys_early: got %h, expected 0000", keys); end
    pressed = 16'h0040;
    exp_q.push_back(4'd6);
    wait_frames(6);
    n_cmp++; if (keys !== 16'h0040) begin n_bad++; $display("FAIL bounce_keys: got %h, expected 0040", keys); end
    n_cmp++; if (keys_changes != 1) begin n_bad++; $display("FAIL bounce_keys_changes: got %0d, expected 1", keys_changes); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bounce_events_pending: got %0d undelivered, expected 0", exp_q.size()); end
    pressed = 16'h0;
    wait_frames(5);
  endtask

  task automatic test_two_keys();
    bit seen;
    do_reset();
    key_ready = 1'b0;
    pressed = 16'h0208;
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd9);
    seen = 1'b0;
    for (int i = 0; i < 10 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL two_valid_timeout: got no key_valid, expected 1"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (keys !== 16'h0208) begin n_bad++; $display("FAIL two_keys_map: got %h, expected 0208", keys); end
    n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin n_bad++; $display("FAIL two_hold: got valid=%b code=%0d, expected valid=1 code=3", key_valid, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin n_bad++; $display("FAIL two_b2b: got valid=%b code=%0d, expected valid=1 code=9", key_valid, key_code); end
    @(negedge clk);
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL two_empty: got %b, expected 0", key_valid); end
    pressed = 16'h0;
    wait_frames(5);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL two_events_pending: got %0d undelivered, expected 0", exp_q.size()); end
  endtask

  task automatic test_overrun_ghost();
    int kc;
    do_reset();
    key_ready = 1'b0;
    pressed = 16'h0020;
    exp_q.push_back(4'd5);
    wait_frames(5);
    n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin n_bad++; $display("FAIL ovr_first: got valid=%b code=%0d, expected valid=1 code=5", key_valid, key_code); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b, expected 0", overrun); end
    pressed = 16'h0;
    wait_frames(5);
    n_cmp++; if (keys !== 16'h0) begin n_bad++; $display("FAIL ovr_release: got %h, expected 0000", keys); end
    pressed = 16'h0020;
    wait_frames(5);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
    key_ready = 1'b1;
    wait_frames(2);
    pressed = 16'h0;
    wait_frames(5);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ovr_events_pending: got %0d undelivered, expected 0", exp_q.size()); end
    kc = keys_changes;
    pressed = 16'h0007;
    wait_frames(6);
    n_cmp++; if (keys !== 16'h0) begin n_bad++; $display("FAIL ghost_keys: got %h, expected 0000", keys); end
    n_cmp++; if (keys_changes != kc) begin n_bad++; $display("FAIL ghost_changes: got %0d, expected %0d", keys_changes, kc); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL ghost_valid: got %b, expected 0", key_valid); end
    pressed = 16'h0;
    wait_frames(2);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int t_upd;
    int n_before;
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0001;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'd0);
    t_upd = -1;
    for (int i = 0; i < 10 * FRAME && t_upd < 0; i++) begin
      @(negedge clk);
      if (keys == 16'h0001) t_upd = cyc;
    end
    n_cmp++; if (t_upd < 0) begin n_bad++; $display("FAIL rep_press_timeout: got keys=%h, expected 0001", keys); end
    for (int i = 0; i < 16 * FRAME && got_t.size() < 4; i++) @(negedge clk);
    n_cmp++;
    if (got_t.size() < 4) begin
      n_bad++;
      $display("FAIL rep_count: got %0d events, expected 4", got_t.size());
    end else begin
      n_cmp++; if (got_t[0] - t_upd != 1) begin n_bad++; $display("FAIL rep_first: got %0d cycles after update, expected 1", got_t[0] - t_upd); end
      n_cmp++; if (got_t[1] - got_t[0] != 8 * FRAME) begin n_bad++; $display("FAIL rep_delay: got %0d, expected %0d", got_t[1] - got_t[0], 8 * FRAME); end
      n_cmp++; if (got_t[2] - got_t[0] != 10 * FRAME) begin n_bad++; $display("FAIL rep_rate1: got %0d, expected %0d", got_t[2] - got_t[0], 10 * FRAME); end
      n_cmp++; if (got_t[3] - got_t[0] != 12 * FRAME) begin n_bad++; $display("FAIL rep_rate2: got %0d, expected %0d", got_t[3] - got_t[0], 12 * FRAME); end
    end
    // Repeats may still fire while the release is being debounced.
    sb_on = 1'b0;
    pressed = 16'h0;
    for (int i = 0; i < 8 * FRAME && keys != 16'h0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_before = got_t.size();
    wait_frames(6);
    n_cmp++; if (got_t.size() != n_before) begin n_bad++; $display("FAIL rep_stop: got %0d events after release, expected 0", got_t.size() - n_before); end
    sb_on = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_overrun_ghost();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
